wb_master_adapter: RTL and testbench

WB_MASTER_ADAPTER -- requirements
Module: wb_master_adapter

---
 rtl/wb_master_adapter.sv | 137 +++++++++++++
 tb/tb_wb_master_adapter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_master_adapter.sv
// Valid/ready to classic Wishbone single-transfer master adapter with ack timeout.
// Latency: accept at edge N, wb_cyc/wb_stb from cycle N+1, rsp_valid no earlier than cycle N+2.
// Backpressure: one transfer in flight; req_ready low outside IDLE, response held until rsp_ready.
//
// Ports:
//   clk, rst                     single clock, synchronous active-high reset
//   req_valid/req_ready          upstream request handshake (req_adr, req_wdata, req_we, req_sel)
//   rsp_valid/rsp_ready          upstream response handshake (rsp_rdata, rsp_err)
//   wb_adr, wb_datwr, wb_we,     Wishbone master outputs, registered at request accept
//   wb_sel, wb_cyc, wb_stb
//   wb_datrd, wb_ack             Wishbone master inputs, only sampled while in BUS
module wb_master_adapter #(
    parameter int ADR_WIDTH = 8,
    parameter int DAT_WIDTH = 8,
    parameter int SEL_WIDTH = 8,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADR_WIDTH-1:0] req_adr,
    input  logic [DAT_WIDTH-1:0] req_wdata,
    input  logic                 req_we,
    input  logic [SEL_WIDTH-1:0] req_sel,

    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DAT_WIDTH-1:0] rsp_rdata,
    output logic                 rsp_err,

    output logic [ADR_WIDTH-1:0] wb_adr,
    output logic [DAT_WIDTH-1:0] wb_datwr,
    output logic                 wb_we,
    output logic [SEL_WIDTH-1:0] wb_sel,
    output logic                 wb_cyc,
    output logic                 wb_stb,
    input  logic [DAT_WIDTH-1:0] wb_datrd,
    input  logic                 wb_ack
);

    // The counter only ever needs to reach TIMEOUT-1: the timeout fires on the
    // edge that closes the last allowed BUS cycle.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit TMO_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;

    logic accept;
    logic ack_hit;
    logic tmo_hit;

    // Handshake and bus-control outputs are pure decodes of the state register,
    // so they are glitch-free and change only at clock edges.
    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign wb_cyc    = (state == BUS);
    assign wb_stb    = (state == BUS);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        ack_hit   = 1'b0;
        tmo_hit   = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = BUS;
                end
            end
            BUS: begin
                // Ack wins over a timeout landing on the same cycle.
                if (wb_ack) begin
                    ack_hit   = 1'b1;
                    state_nxt = RESP;
                end else if (TMO_EN && (cnt == TMO_LAST)) begin
                    tmo_hit   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            wb_adr    <= '0;
            wb_datwr  <= '0;
            wb_we     <= 1'b0;
            wb_sel    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;

            if (accept) begin
                wb_adr   <= req_adr;
                wb_datwr <= req_wdata;
                wb_we    <= req_we;
                wb_sel   <= req_sel;
                cnt      <= '0;
            end else if (TMO_EN && (state == BUS) && (cnt != TMO_LAST)) begin
                cnt <= cnt + CNT_W'(1);
            end

            // Writes return zero data so a stale read value never leaks upstream.
            if (ack_hit) begin
                rsp_rdata <= wb_we ? '0 : wb_datrd;
                rsp_err   <= 1'b0;
            end else if (tmo_hit) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_master_adapter.sv
module tb_wb_master_adapter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_adr;
    logic [7:0] req_wdata;
    logic       req_we;
    logic [7:0] req_sel;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic [7:0] wb_adr;
    logic [7:0] wb_datwr;
    logic       wb_we;
    logic [7:0] wb_sel;
    logic       wb_cyc;
    logic       wb_stb;
    logic [7:0] wb_datrd;
    logic       wb_ack;

    int checks = 0;
    int passes = 0;
    int ncyc;

    always #5 clk = ~clk;

    wb_master_adapter #(
        .ADR_WIDTH(8),
        .DAT_WIDTH(8),
        .SEL_WIDTH(8),
        .TIMEOUT  (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_adr  (req_adr),
        .req_wdata(req_wdata),
        .req_we   (req_we),
        .req_sel  (req_sel),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .wb_adr   (wb_adr),
        .wb_datwr (wb_datwr),
        .wb_we    (wb_we),
        .wb_sel   (wb_sel),
        .wb_cyc   (wb_cyc),
        .wb_stb   (wb_stb),
        .wb_datrd (wb_datrd),
        .wb_ack   (wb_ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic issue(input logic [7:0] adr, input logic [7:0] wdata,
                         input logic we, input logic [7:0] sel);
        req_valid = 1'b1;
        req_adr   = adr;
        req_wdata = wdata;
        req_we    = we;
        req_sel   = sel;
        chk("issue_req_ready", {31'd0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        req_adr   = 8'hEE;
        req_wdata = 8'hEE;
        req_sel   = 8'h00;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_adr   = 8'h00;
        req_wdata = 8'h00;
        req_we    = 1'b0;
        req_sel   = 8'h00;
        rsp_ready = 1'b1;
        wb_datrd  = 8'h00;
        wb_ack    = 1'b0;

        // ---- reset state ----
        tick(); tick(); tick();
        chk("rst_cyc",       {31'd0, wb_cyc},    32'd0);
        chk("rst_stb",       {31'd0, wb_stb},    32'd0);
        chk("rst_we",        {31'd0, wb_we},     32'd0);
        chk("rst_adr",       {24'd0, wb_adr},    32'h00);
        chk("rst_datwr",     {24'd0, wb_datwr},  32'h00);
        chk("rst_sel",       {24'd0, wb_sel},    32'h00);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rdata",     {24'd0, rsp_rdata}, 32'h00);
        chk("rst_err",       {31'd0, rsp_err},   32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

        // ---- read, ack in first BUS cycle ----
        issue(8'h12, 8'h00, 1'b0, 8'hFF);
        chk("rd_cyc",       {31'd0, wb_cyc},    32'd1);
        chk("rd_stb",       {31'd0, wb_stb},    32'd1);
        chk("rd_adr",       {24'd0, wb_adr},    32'h12);
        chk("rd_we",        {31'd0, wb_we},     32'd0);
        chk("rd_sel",       {24'd0, wb_sel},    32'hFF);
        chk("rd_ready_bus", {31'd0, req_ready}, 32'd0);
        chk("rd_valid_n1",  {31'd0, rsp_valid}, 32'd0);
        wb_ack   = 1'b1;
        wb_datrd = 8'hA5;
        tick();
        wb_ack   = 1'b0;
        wb_datrd = 8'h00;
        chk("rd_cyc_drop",  {31'd0, wb_cyc},    32'd0);
        chk("rd_stb_drop",  {31'd0, wb_stb},    32'd0);
        chk("rd_valid_n2",  {31'd0, rsp_valid}, 32'd1);
        chk("rd_rdata",     {24'd0, rsp_rdata}, 32'hA5);
        chk("rd_err",       {31'd0, rsp_err},   32'd0);
        tick();
        chk("rd_valid_done", {31'd0, rsp_valid}, 32'd0);
        chk("rd_idle_ready", {31'd0, req_ready}, 32'd1);

        // ---- timeout: no ack for 16 BUS cycles ----
        issue(8'h56, 8'h00, 1'b0, 8'h0F);
        ncyc = 0;
        for (int i = 0; i < 40 && wb_cyc; i++) begin
            ncyc++;
            tick();
        end
        chk("tmo_bus_cycles", ncyc,                  32'd16);
        chk("tmo_cyc_drop",   {31'd0, wb_cyc},       32'd0);
        chk("tmo_stb_drop",   {31'd0, wb_stb},       32'd0);
        chk("tmo_valid",      {31'd0, rsp_valid},    32'd1);
        chk("tmo_err",        {31'd0, rsp_err},      32'd1);
        chk("tmo_rdata",      {24'd0, rsp_rdata},    32'h00);
        tick();
        chk("tmo_idle",       {31'd0, req_ready},    32'd1);

        // ---- write with ack in third BUS cycle ----
        wb_datrd = 8'hC3;
        issue(8'h34, 8'h5A, 1'b1, 8'h01);
        for (int i = 0; i < 3; i++) begin
            chk("wr_cyc",   {31'd0, wb_cyc},   32'd1);
            chk("wr_stb",   {31'd0, wb_stb},   32'd1);
            chk("wr_adr",   {24'd0, wb_adr},   32'h34);
            chk("wr_datwr", {24'd0, wb_datwr}, 32'h5A);
            chk("wr_we",    {31'd0, wb_we},    32'd1);
            chk("wr_sel",   {24'd0, wb_sel},   32'h01);
            if (i == 2) wb_ack = 1'b1;
            tick();
        end
        wb_ack = 1'b0;
        chk("wr_cyc_drop", {31'd0, wb_cyc},    32'd0);
        chk("wr_valid",    {31'd0, rsp_valid}, 32'd1);
        chk("wr_rdata",    {24'd0, rsp_rdata}, 32'h00);
        chk("wr_err",      {31'd0, rsp_err},   32'd0);
        tick();

        // ---- ack exactly on the 16th BUS cycle beats the timeout ----
        issue(8'h60, 8'h00, 1'b0, 8'h03);
        for (int i = 1; i <= 16; i++) begin
            chk("a16_cyc", {31'd0, wb_cyc}, 32'd1);
            if (i == 16) begin
                wb_ack   = 1'b1;
                wb_datrd = 8'h3C;
            end
            tick();
        end
        wb_ack   = 1'b0;
        wb_datrd = 8'h00;
        chk("a16_cyc_drop", {31'd0, wb_cyc},    32'd0);
        chk("a16_valid",    {31'd0, rsp_valid}, 32'd1);
        chk("a16_err",      {31'd0, rsp_err},   32'd0);
        chk("a16_rdata",    {24'd0, rsp_rdata}, 32'h3C);
        tick();

        // ---- response backpressure with stray ack and request ----
        rsp_ready = 1'b0;
        issue(8'h78, 8'h00, 1'b0, 8'hF0);
        wb_ack   = 1'b1;
        wb_datrd = 8'h99;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rdata", {24'd0, rsp_rdata}, 32'h99);
            chk("bp_err",   {31'd0, rsp_err},   32'd0);
            chk("bp_ready", {31'd0, req_ready}, 32'd0);
            chk("bp_cyc",   {31'd0, wb_cyc},    32'd0);
            wb_ack    = 1'b1;
            wb_datrd  = 8'h11;
            req_valid = 1'b1;
            req_adr   = 8'hAB;
            tick();
        end
        chk("bp_rdata_end", {24'd0, rsp_rdata}, 32'h99);
        req_valid = 1'b0;
        wb_ack    = 1'b0;
        rsp_ready = 1'b1;
        tick();
        chk("bp_released", {31'd0, rsp_valid}, 32'd0);
        chk("bp_idle",     {31'd0, req_ready}, 32'd1);
        chk("bp_no_xfer",  {31'd0, wb_cyc},    32'd0);

        // ---- reset while waiting in BUS ----
        issue(8'h9A, 8'h77, 1'b1, 8'h02);
        chk("rb_cyc_wait", {31'd0, wb_cyc}, 32'd1);
        tick();
        chk("rb_cyc_wait2", {31'd0, wb_cyc}, 32'd1);
        rst = 1'b1;
        tick();
        chk("rb_cyc",   {31'd0, wb_cyc},    32'd0);
        chk("rb_stb",   {31'd0, wb_stb},    32'd0);
        chk("rb_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rb_adr",   {24'd0, wb_adr},    32'h00);
        chk("rb_we",    {31'd0, wb_we},     32'd0);
        rst = 1'b0;
        tick();
        chk("rb_ready", {31'd0, req_ready}, 32'd1);
        wb_ack = 1'b1;
        ncyc = 0;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid || wb_cyc) ncyc++;
            tick();
        end
        wb_ack = 1'b0;
        chk("rb_no_rsp", ncyc, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
